gf180mcu_fd_sc_mcu9t5v0__invz_busrx: RTL and testbench

Receive end of a shared tristate bus built from invz-style inverting tristate drivers (one active-high enable per driver).
- Samples the bus and the per-driver enables, and classifies each cycle as floating, singly driven or contended.
- Captures a word only once it has been stable for a set number of cycles, then offers it on a valid/ready port.
- Supplies the bus-keeper value.
- Sits at the consumer side of a multi-drop bus in the same clock domain as the drivers.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__invz_busrx.sv | 148 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__invz_busrx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_busrx.sv
// Receive end of a shared inverting-tristate bus: samples the bus and the
// per-driver enables, waits for a stable singly-driven word, then offers it
// on a valid/ready port and exports the raw word for the bus keeper.
//
// Ports:
//   CLK, RST     clock (rising edge), asynchronous active-high reset
//   BUS, EN      resolved bus value and driver enables (sampled every cycle)
//   CLR          synchronous clear of the sticky COLL/OVF flags
//   DOUT, DSRC   captured word (polarity per INVERT) and its driver index
//   DVALID       DOUT/DSRC valid; DREADY accepts the word
//   KEEP         raw value of the last captured bus word (bus keeper)
//   FLOAT        no driver enabled in the last sample
//   COLL, OVF    sticky: contention seen / capture dropped on a full buffer
//   VDD, VSS     supply pins, no logical function

module gf180mcu_fd_sc_mcu9t5v0__invz_busrx #(
  parameter int WIDTH  = 8,
  parameter int NDRV   = 4,
  parameter int INVERT = 1,
  parameter int SETTLE = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [WIDTH-1:0]        BUS,
  input  logic [NDRV-1:0]         EN,
  input  logic                    CLR,
  output logic [WIDTH-1:0]        DOUT,
  output logic [$clog2(NDRV)-1:0] DSRC,
  output logic                    DVALID,
  input  logic                    DREADY,
  output logic [WIDTH-1:0]        KEEP,
  output logic                    FLOAT,
  output logic                    COLL,
  output logic                    OVF,
  inout  wire                     VDD,
  inout  wire                     VSS
);

  localparam int SW = $clog2(NDRV);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_FLOAT,
    S_SETTLE,
    S_HOLD,
    S_CONTEND
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] bus_p;
  logic [NDRV-1:0]  en_q;
  logic [SW-1:0]    idx;
  logic [SW-1:0]    idx_p;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    run;
  logic             none;
  logic             one;
  logic             many;
  logic             same;
  logic             track;
  logic             cap;
  logic             drop;

  // Supply pins carry no logic; folded here so they are not dangling.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (en_q[i]) idx = SW'(i);
    end
  end

  // One-hot test: a single set bit clears when ANDed with itself minus one.
  always_comb begin
    none  = (en_q == '0);
    one   = !none && ((en_q & (en_q - NDRV'(1))) == '0);
    many  = !none && !one;
    same  = (bus_q == bus_p) && (idx == idx_p);
    track = (state == S_SETTLE) || (state == S_HOLD);
    // run is the stability count this sample would give; fresh entries
    // and changed samples start over at zero.
    run   = (track && same) ? cnt + CW'(1) : '0;
    cap   = one && !(state == S_HOLD && same) && (run == LAST);
    drop  = cap && DVALID && !DREADY;
  end

  // FLOAT comes straight from the enable sample register.
  assign FLOAT = none;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_FLOAT;
      bus_q  <= '0;
      bus_p  <= '0;
      en_q   <= '0;
      idx_p  <= '0;
      cnt    <= '0;
      DOUT   <= '0;
      DSRC   <= '0;
      DVALID <= 1'b0;
      KEEP   <= '0;
      COLL   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      bus_q <= BUS;
      en_q  <= EN;
      bus_p <= bus_q;
      idx_p <= idx;

      if (many) begin
        state <= S_CONTEND;
        cnt   <= '0;
      end else if (none) begin
        state <= S_FLOAT;
        cnt   <= '0;
      end else if (cap) begin
        state <= S_HOLD;
        cnt   <= run;
      end else if (!(state == S_HOLD && same)) begin
        state <= S_SETTLE;
        cnt   <= run;
      end

      if (cap) begin
        KEEP <= bus_q;
        if (!drop) begin
          DOUT   <= (INVERT != 0) ? ~bus_q : bus_q;
          DSRC   <= idx;
          DVALID <= 1'b1;
        end
      end else if (DVALID && DREADY) begin
        DVALID <= 1'b0;
      end

      // A set event outranks a clear in the same cycle.
      if (many) COLL <= 1'b1;
      else if (CLR) COLL <= 1'b0;

      if (drop) OVF <= 1'b1;
      else if (CLR) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__invz_busrx.sv
// Directed bench for the invz bus receiver.
// Linear stimulus, immediate assertions at every comparison point.

module tb_gf180mcu_fd_sc_mcu9t5v0__invz_busrx;

  logic       clk;
  logic       rst;
  logic [7:0] bus;
  logic [3:0] en;
  logic       clr;
  logic [7:0] dout;
  logic [1:0] dsrc;
  logic       dvalid;
  logic       dready;
  logic [7:0] keep;
  logic       float_o;
  logic       coll;
  logic       ovf;
  wire        vdd;
  wire        vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks;
  int failures;

  gf180mcu_fd_sc_mcu9t5v0__invz_busrx #(
    .WIDTH(8), .NDRV(4), .INVERT(1), .SETTLE(3)
  ) dut (
    .CLK(clk), .RST(rst), .BUS(bus), .EN(en), .CLR(clr),
    .DOUT(dout), .DSRC(dsrc), .DVALID(dvalid), .DREADY(dready),
    .KEEP(keep), .FLOAT(float_o), .COLL(coll), .OVF(ovf),
    .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] e, input logic [7:0] b);
    en  = e;
    bus = b;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dvalid"}, 32'(dvalid), 32'h0);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_dsrc"}, 32'(dsrc), 32'h0);
    chk({tag, "_keep"}, 32'(keep), 32'h0);
    chk({tag, "_float"}, 32'(float_o), 32'h1);
    chk({tag, "_coll"}, 32'(coll), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    dready   = 1'b1;
    drive(4'b0000, 8'h00);
    #3;
    chk_reset("rst0");
    step(2);
    rst = 1'b0;
    step(2);
    chk("idle_float", 32'(float_o), 32'h1);

    // Basic capture: A5 from driver 1, inverted to 5A after 3 settle edges.
    drive(4'b0010, 8'hA5);
    step(1);
    chk("basic_float0", 32'(float_o), 32'h0);
    step(2);
    chk("basic_early", 32'(dvalid), 32'h0);
    step(1);
    chk("basic_valid", 32'(dvalid), 32'h1);
    chk("basic_dout", 32'(dout), 32'h5A);
    chk("basic_dsrc", 32'(dsrc), 32'h1);
    chk("basic_keep", 32'(keep), 32'hA5);
    step(1);
    chk("basic_onecyc", 32'(dvalid), 32'h0);
    step(2);
    chk("basic_norecap", 32'(dvalid), 32'h0);

    // Float, then glitch rejection: 3C for two cycles, 3D held.
    drive(4'b0000, 8'h00);
    step(1);
    chk("float_after1", 32'(float_o), 32'h1);
    step(1);
    drive(4'b0001, 8'h3C);
    step(2);
    bus = 8'h3D;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch_nocap", 32'(dvalid), 32'h0);
    end
    step(1);
    chk("glitch_valid", 32'(dvalid), 32'h1);
    chk("glitch_dout", 32'(dout), 32'hC2);
    chk("glitch_dsrc", 32'(dsrc), 32'h0);
    chk("glitch_keep", 32'(keep), 32'h3D);
    step(1);
    chk("glitch_once", 32'(dvalid), 32'h0);

    // Contention for one cycle, then driver 2 alone with 0F.
    drive(4'b0000, 8'h00);
    step(2);
    chk("cont_coll0", 32'(coll), 32'h0);
    drive(4'b0110, 8'h0F);
    step(1);
    en = 4'b0100;
    step(1);
    chk("cont_coll1", 32'(coll), 32'h1);
    step(2);
    chk("cont_early", 32'(dvalid), 32'h0);
    step(1);
    chk("cont_valid", 32'(dvalid), 32'h1);
    chk("cont_dsrc", 32'(dsrc), 32'h2);
    chk("cont_dout", 32'(dout), 32'hF0);
    step(2);
    chk("cont_sticky", 32'(coll), 32'h1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("cont_clr", 32'(coll), 32'h0);

    // Set event and CLR on the same edge: set wins.
    drive(4'b0011, 8'h55);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("coll_setwins", 32'(coll), 32'h1);
    drive(4'b0000, 8'h00);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("coll_clr2", 32'(coll), 32'h0);
    step(1);

    // Overflow: two captures with DREADY low, second is dropped.
    dready = 1'b0;
    drive(4'b0001, 8'h11);
    step(4);
    chk("ovf_first", 32'(dvalid), 32'h1);
    chk("ovf_dout1", 32'(dout), 32'hEE);
    drive(4'b1000, 8'h22);
    step(3);
    chk("ovf_notyet", 32'(ovf), 32'h0);
    step(1);
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_keep", 32'(keep), 32'h22);
    chk("ovf_dout", 32'(dout), 32'hEE);
    chk("ovf_dsrc", 32'(dsrc), 32'h0);
    chk("ovf_valid", 32'(dvalid), 32'h1);
    dready = 1'b1;
    step(1);
    chk("ovf_xfer", 32'(dvalid), 32'h0);
    step(1);
    chk("ovf_onexfer", 32'(dvalid), 32'h0);
    chk("ovf_sticky", 32'(ovf), 32'h1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);

    // Float/keeper: capture 81, float, re-enable same driver and data.
    drive(4'b0000, 8'h00);
    step(2);
    drive(4'b0001, 8'h81);
    step(4);
    chk("keep_cap", 32'(dvalid), 32'h1);
    chk("keep_dout", 32'(dout), 32'h7E);
    step(1);
    drive(4'b0000, 8'h00);
    step(1);
    chk("keep_float", 32'(float_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("keep_hold", 32'({dvalid, keep}), 32'h081);
    end
    drive(4'b0001, 8'h81);
    step(3);
    chk("reen_early", 32'(dvalid), 32'h0);
    step(1);
    chk("reen_valid", 32'(dvalid), 32'h1);
    chk("reen_dout", 32'(dout), 32'h7E);

    // Data change with the same driver while holding must re-settle.
    bus = 8'h82;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("chg_wait", 32'(dvalid), 32'h0);
    end
    step(1);
    chk("chg_valid", 32'(dvalid), 32'h1);
    chk("chg_dout", 32'(dout), 32'h7D);
    chk("chg_keep", 32'(keep), 32'h82);

    // Asynchronous reset mid-handshake, checked before any clock edge.
    dready = 1'b0;
    en = 4'b1100;
    step(1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    dready = 1'b1;
    drive(4'b0000, 8'h00);
    step(1);
    rst = 1'b0;
    step(3);
    chk("post_rst_valid", 32'(dvalid), 32'h0);
    chk("post_rst_coll", 32'(coll), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
